// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register: operand forwarding, ALU decode,
// destination select, with stall (hold) and flush (bubble) control.
module ex_mem_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  WB_i,
   input  logic [1:0]  MEM_i,
   input  logic        ALU_Src_i,
   input  logic [1:0]  ALU_OP_i,
   input  logic        Reg_Dst_i,
   input  logic [31:0] Reg_data1_i,
   input  logic [31:0] Reg_data2_i,
   input  logic [31:0] immd_i,
   input  logic [4:0]  RsAddr_i,
   input  logic [4:0]  RtAddr_i,
   input  logic [4:0]  RdAddr_i,
   input  logic        WB_RegWrite_i,
   input  logic [4:0]  WB_RdAddr_i,
   input  logic [31:0] WB_data_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic [1:0]  WB_o,
   output logic [1:0]  MEM_o,
   output logic [31:0] ALU_result_o,
   output logic [31:0] MemWriteData_o,
   output logic [4:0]  RdAddr_o,
   output logic [1:0]  Fwd_A_o,
   output logic [1:0]  Fwd_B_o
);

   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] op_a, rt_val, op_b, alu_res;
   logic [4:0]  dst;
   logic [5:0]  funct;

   // EX/MEM match takes priority over WB; $0 never forwards.
   always_comb begin
      fwd_a = 2'b00;
      if (WB_o[1] && (RdAddr_o != 5'd0) && (RdAddr_o == RsAddr_i))
         fwd_a = 2'b10;
      else if (WB_RegWrite_i && (WB_RdAddr_i != 5'd0) && (WB_RdAddr_i == RsAddr_i))
         fwd_a = 2'b01;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (WB_o[1] && (RdAddr_o != 5'd0) && (RdAddr_o == RtAddr_i))
         fwd_b = 2'b10;
      else if (WB_RegWrite_i && (WB_RdAddr_i != 5'd0) && (WB_RdAddr_i == RtAddr_i))
         fwd_b = 2'b01;
   end

   always_comb begin
      case (fwd_a)
         2'b10:   op_a = ALU_result_o;
         2'b01:   op_a = WB_data_i;
         default: op_a = Reg_data1_i;
      endcase
      case (fwd_b)
         2'b10:   rt_val = ALU_result_o;
         2'b01:   rt_val = WB_data_i;
         default: rt_val = Reg_data2_i;
      endcase
   end

   assign op_b  = ALU_Src_i ? immd_i : rt_val;
   assign funct = immd_i[5:0];
   assign dst   = Reg_Dst_i ? RdAddr_i : RtAddr_i;

   // Low 32 bits of a product are identical for signed and unsigned operands.
   always_comb begin
      alu_res = 32'd0;
      case (ALU_OP_i)
         2'b00: alu_res = op_a + op_b;
         2'b01: alu_res = op_a - op_b;
         2'b11: alu_res = op_a | op_b;
         default: begin
            case (funct)
               6'b100000: alu_res = op_a + op_b;
               6'b100010: alu_res = op_a - op_b;
               6'b100100: alu_res = op_a & op_b;
               6'b100101: alu_res = op_a | op_b;
               6'b101010: alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
               6'b011000: alu_res = op_a * op_b;
               default:   alu_res = 32'd0;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         WB_o           <= 2'b00;
         MEM_o          <= 2'b00;
         ALU_result_o   <= 32'd0;
         MemWriteData_o <= 32'd0;
         RdAddr_o       <= 5'd0;
      end else if (flush_i) begin
         WB_o           <= 2'b00;
         MEM_o          <= 2'b00;
         ALU_result_o   <= 32'd0;
         MemWriteData_o <= 32'd0;
         RdAddr_o       <= 5'd0;
      end else if (!stall_i) begin
         WB_o           <= WB_i;
         MEM_o          <= MEM_i;
         ALU_result_o   <= alu_res;
         MemWriteData_o <= rt_val;
         RdAddr_o       <= dst;
      end
   end

   assign Fwd_A_o = fwd_a;
   assign Fwd_B_o = fwd_b;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized
// traffic against a behavioural model of the EX/MEM register.
module tb_ex_mem_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  WB_i, MEM_i, ALU_OP_i;
   logic        ALU_Src_i, Reg_Dst_i, WB_RegWrite_i, stall_i, flush_i;
   logic [31:0] Reg_data1_i, Reg_data2_i, immd_i, WB_data_i;
   logic [4:0]  RsAddr_i, RtAddr_i, RdAddr_i, WB_RdAddr_i;
   logic [1:0]  WB_o, MEM_o, Fwd_A_o, Fwd_B_o;
   logic [31:0] ALU_result_o, MemWriteData_o;
   logic [4:0]  RdAddr_o;

   int n_checks = 0;
   int n_fail   = 0;

   ex_mem_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .MEM_i(MEM_i),
      .ALU_Src_i(ALU_Src_i), .ALU_OP_i(ALU_OP_i), .Reg_Dst_i(Reg_Dst_i),
      .Reg_data1_i(Reg_data1_i), .Reg_data2_i(Reg_data2_i), .immd_i(immd_i),
      .RsAddr_i(RsAddr_i), .RtAddr_i(RtAddr_i), .RdAddr_i(RdAddr_i),
      .WB_RegWrite_i(WB_RegWrite_i), .WB_RdAddr_i(WB_RdAddr_i), .WB_data_i(WB_data_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .WB_o(WB_o), .MEM_o(MEM_o), .ALU_result_o(ALU_result_o),
      .MemWriteData_o(MemWriteData_o), .RdAddr_o(RdAddr_o),
      .Fwd_A_o(Fwd_A_o), .Fwd_B_o(Fwd_B_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic clear_inputs();
      WB_i = 0; MEM_i = 0; ALU_Src_i = 0; ALU_OP_i = 0; Reg_Dst_i = 0;
      Reg_data1_i = 0; Reg_data2_i = 0; immd_i = 0;
      RsAddr_i = 0; RtAddr_i = 0; RdAddr_i = 0;
      WB_RegWrite_i = 0; WB_RdAddr_i = 0; WB_data_i = 0;
      stall_i = 0; flush_i = 0;
   endtask

   task automatic flush_cycle();
      @(negedge clk_i); clear_inputs(); flush_i = 1;
      @(posedge clk_i); #1;
   endtask

   // Reference ALU written from the operation table.
   function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [5:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
      longint p;
      if (op == 2'b00) return a + b;
      if (op == 2'b01) return a - b;
      if (op == 2'b11) return a | b;
      case (f)
         6'd32: return a + b;
         6'd34: return a - b;
         6'd36: return a & b;
         6'd37: return a | b;
         6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'd24: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
         default: return 32'd0;
      endcase
   endfunction

   task automatic test_reset();
      n_checks++;
      if ({WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o} !== 73'd0) begin
         n_fail++; $display("FAIL reset_initial: got %h want 0", {WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o});
      end
      @(negedge clk_i); rst_i = 1;
      clear_inputs();
      Reg_data1_i = 5; Reg_data2_i = 7; Reg_Dst_i = 1; RdAddr_i = 3; WB_i = 2'b10; MEM_i = 2'b01;
      RsAddr_i = 1; RtAddr_i = 2;
      @(posedge clk_i); #1;
      n_checks++;
      if (ALU_result_o !== 32'd12 || RdAddr_o !== 5'd3 || MemWriteData_o !== 32'd7) begin
         n_fail++; $display("FAIL reset_preload: got res=%0d rd=%0d wd=%0d want 12 3 7", ALU_result_o, RdAddr_o, MemWriteData_o);
      end
      @(negedge clk_i); stall_i = 1; #2 rst_i = 0; #1;
      n_checks++;
      if ({WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o} !== 73'd0) begin
         n_fail++; $display("FAIL reset_async: got %h want 0", {WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o});
      end
      stall_i = 0;
      @(posedge clk_i); #1;
      @(negedge clk_i); rst_i = 1; #1;
      n_checks++;
      if ({WB_o, ALU_result_o, RdAddr_o} !== 39'd0) begin
         n_fail++; $display("FAIL reset_release_hold: got %h want 0", {WB_o, ALU_result_o, RdAddr_o});
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (ALU_result_o !== 32'd12) begin
         n_fail++; $display("FAIL reset_first_load: got %0d want 12", ALU_result_o);
      end
   endtask

   task automatic test_add_rtype();
      flush_cycle();
      @(negedge clk_i); clear_inputs();
      Reg_data1_i = 5; Reg_data2_i = 7; ALU_OP_i = 2'b10; immd_i = 32'h20;
      Reg_Dst_i = 1; RdAddr_i = 3; WB_i = 2'b10; RsAddr_i = 1; RtAddr_i = 2;
      @(posedge clk_i); #1;
      n_checks++;
      if (ALU_result_o !== 32'd12 || RdAddr_o !== 5'd3 || WB_o !== 2'b10) begin
         n_fail++; $display("FAIL add_rtype: got res=%0d rd=%0d wb=%b want 12 3 10", ALU_result_o, RdAddr_o, WB_o);
      end
   endtask

   task automatic test_double_hazard();
      flush_cycle();
      @(negedge clk_i); clear_inputs();
      RsAddr_i = 1; RtAddr_i = 2; Reg_data1_i = 60; ALU_Src_i = 1; immd_i = 40;
      Reg_Dst_i = 1; RdAddr_i = 4; WB_i = 2'b10;
      @(posedge clk_i); #1;
      @(negedge clk_i); clear_inputs();
      RsAddr_i = 4; RtAddr_i = 5; Reg_data1_i = 0; Reg_data2_i = 1; ALU_OP_i = 2'b01;
      WB_RegWrite_i = 1; WB_RdAddr_i = 4; WB_data_i = 200; Reg_Dst_i = 1; RdAddr_i = 6; WB_i = 2'b10;
      #1;
      n_checks++;
      if (Fwd_A_o !== 2'b10 || Fwd_B_o !== 2'b00) begin
         n_fail++; $display("FAIL double_hazard_sel: got A=%b B=%b want 10 00", Fwd_A_o, Fwd_B_o);
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (ALU_result_o !== 32'd99) begin
         n_fail++; $display("FAIL double_hazard_res: got %0d want 99", ALU_result_o);
      end
   endtask

   task automatic test_zero_guard();
      flush_cycle();
      @(negedge clk_i); clear_inputs();
      RsAddr_i = 1; Reg_data1_i = 55; ALU_Src_i = 1; Reg_Dst_i = 1; RdAddr_i = 0; WB_i = 2'b10;
      @(posedge clk_i); #1;
      @(negedge clk_i); clear_inputs();
      RsAddr_i = 0; RtAddr_i = 0; ALU_Src_i = 1; immd_i = 3; Reg_Dst_i = 1; RdAddr_i = 7;
      WB_RegWrite_i = 1; WB_RdAddr_i = 0; WB_data_i = 77;
      #1;
      n_checks++;
      if (Fwd_A_o !== 2'b00 || Fwd_B_o !== 2'b00) begin
         n_fail++; $display("FAIL zero_guard_sel: got A=%b B=%b want 00 00", Fwd_A_o, Fwd_B_o);
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (ALU_result_o !== 32'd3) begin
         n_fail++; $display("FAIL zero_guard_res: got %0d want 3", ALU_result_o);
      end
   endtask

   task automatic test_sw_forward();
      flush_cycle();
      @(negedge clk_i); clear_inputs();
      RsAddr_i = 6; Reg_data1_i = 1000; RtAddr_i = 7; Reg_data2_i = 0;
      WB_RegWrite_i = 1; WB_RdAddr_i = 7; WB_data_i = 32'hDEADBEEF;
      ALU_Src_i = 1; immd_i = 8; MEM_i = 2'b01;
      #1;
      n_checks++;
      if (Fwd_B_o !== 2'b01 || Fwd_A_o !== 2'b00) begin
         n_fail++; $display("FAIL sw_sel: got A=%b B=%b want 00 01", Fwd_A_o, Fwd_B_o);
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (MemWriteData_o !== 32'hDEADBEEF || ALU_result_o !== 32'd1008 || MEM_o !== 2'b01) begin
         n_fail++; $display("FAIL sw_data: got wd=%h res=%0d mem=%b want deadbeef 1008 01", MemWriteData_o, ALU_result_o, MEM_o);
      end
   endtask

   task automatic test_stall_flush();
      flush_cycle();
      @(negedge clk_i); clear_inputs();
      RsAddr_i = 1; Reg_data1_i = 32'h1200; ALU_Src_i = 1; immd_i = 32'h34; ALU_OP_i = 2'b11;
      RtAddr_i = 2; Reg_data2_i = 32'h55; Reg_Dst_i = 1; RdAddr_i = 9; WB_i = 2'b11; MEM_i = 2'b10;
      @(posedge clk_i); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         Reg_data1_i = 32'hFFFF; RdAddr_i = 3; WB_i = 0; MEM_i = 0; RsAddr_i = 9; stall_i = 1;
         #1;
         n_checks++;
         if (Fwd_A_o !== 2'b10) begin
            n_fail++; $display("FAIL stall_fwd[%0d]: got %b want 10", i, Fwd_A_o);
         end
         @(posedge clk_i); #1;
         n_checks++;
         if ({WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o} !== {2'b11, 2'b10, 32'h1234, 32'h55, 5'd9}) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i,
               {WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o}, {2'b11, 2'b10, 32'h1234, 32'h55, 5'd9});
         end
      end
      @(negedge clk_i); stall_i = 1; flush_i = 1;
      @(posedge clk_i); #1;
      n_checks++;
      if ({WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o} !== 73'd0) begin
         n_fail++; $display("FAIL stall_flush: got %h want 0", {WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o});
      end
   endtask

   task automatic test_funct();
      logic [31:0] a_t [6] = '{32'hFFFFFFFF, 32'h10000, 32'd9, 32'hF0F0, 32'hF0F0, 32'd20};
      logic [31:0] b_t [6] = '{32'd1, 32'h10000, 32'd4, 32'h0FF0, 32'h0FF0, 32'd25};
      logic [5:0]  f_t [6] = '{6'd42, 6'd24, 6'd7, 6'd36, 6'd37, 6'd34};
      logic [31:0] e_t [6] = '{32'd1, 32'd0, 32'd0, 32'h00F0, 32'hFFF0, 32'hFFFFFFFB};
      flush_cycle();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i); clear_inputs();
         RsAddr_i = 10; RtAddr_i = 11; Reg_data1_i = a_t[i]; Reg_data2_i = b_t[i];
         ALU_OP_i = 2'b10; immd_i = {26'd0, f_t[i]}; Reg_Dst_i = 1; RdAddr_i = 12; WB_i = 2'b10;
         @(posedge clk_i); #1;
         n_checks++;
         if (ALU_result_o !== e_t[i]) begin
            n_fail++; $display("FAIL funct_%b: got %h want %h", f_t[i], ALU_result_o, e_t[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0]  fl [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24, 6'd0};
      logic [1:0]  m_wb, m_mem, fa, fb;
      logic [31:0] m_res, m_wd, a, rt, b, res;
      logic [4:0]  m_rd, dst;
      flush_cycle();
      m_wb = 0; m_mem = 0; m_res = 0; m_wd = 0; m_rd = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         WB_i = 2'($urandom); MEM_i = 2'($urandom); ALU_Src_i = 1'($urandom);
         ALU_OP_i = 2'($urandom); Reg_Dst_i = 1'($urandom);
         Reg_data1_i = $urandom; Reg_data2_i = $urandom; immd_i = $urandom;
         if ($urandom_range(3) != 0) immd_i[5:0] = fl[$urandom_range(6)];
         RsAddr_i = 5'($urandom_range(7)); RtAddr_i = 5'($urandom_range(7)); RdAddr_i = 5'($urandom_range(7));
         WB_RegWrite_i = 1'($urandom); WB_RdAddr_i = 5'($urandom_range(7)); WB_data_i = $urandom;
         stall_i = ($urandom_range(9) == 0); flush_i = ($urandom_range(9) == 0);
         fa = (m_wb[1] && m_rd != 0 && m_rd == RsAddr_i) ? 2'b10 :
              (WB_RegWrite_i && WB_RdAddr_i != 0 && WB_RdAddr_i == RsAddr_i) ? 2'b01 : 2'b00;
         fb = (m_wb[1] && m_rd != 0 && m_rd == RtAddr_i) ? 2'b10 :
              (WB_RegWrite_i && WB_RdAddr_i != 0 && WB_RdAddr_i == RtAddr_i) ? 2'b01 : 2'b00;
         a  = (fa == 2'b10) ? m_res : (fa == 2'b01) ? WB_data_i : Reg_data1_i;
         rt = (fb == 2'b10) ? m_res : (fb == 2'b01) ? WB_data_i : Reg_data2_i;
         b  = ALU_Src_i ? immd_i : rt;
         res = alu_ref(ALU_OP_i, immd_i[5:0], a, b);
         dst = Reg_Dst_i ? RdAddr_i : RtAddr_i;
         #1;
         n_checks++;
         if ({Fwd_A_o, Fwd_B_o} !== {fa, fb}) begin
            n_fail++; $display("FAIL rand_fwd[%0d]: got %b%b want %b%b", i, Fwd_A_o, Fwd_B_o, fa, fb);
         end
         @(posedge clk_i);
         if (flush_i) begin
            m_wb = 0; m_mem = 0; m_res = 0; m_wd = 0; m_rd = 0;
         end else if (!stall_i) begin
            m_wb = WB_i; m_mem = MEM_i; m_res = res; m_wd = rt; m_rd = dst;
         end
         #1;
         n_checks++;
         if ({WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o} !== {m_wb, m_mem, m_res, m_wd, m_rd}) begin
            n_fail++; $display("FAIL rand_reg[%0d]: got %h want %h", i,
               {WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o}, {m_wb, m_mem, m_res, m_wd, m_rd});
         end
      end
   endtask

   initial begin
      rst_i = 0;
      clear_inputs();
      #1;
      test_reset();
      test_add_rtype();
      test_double_hazard();
      test_zero_guard();
      test_sw_forward();
      test_stall_flush();
      test_funct();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
